bubble_spawner: RTL
===================

BUBBLE_SPAWNER -- requirements
Module: bubble_spawner

Interface
REQ-001 Parameter NUM_SLOTS, default 8: number of bubble_move instances driven; range 2..16.
REQ-002 Parameter OBJECT_SIZE, default 8: base bubble width in pixels; a size-s bubble is OBJECT_SIZE<<s wide.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 resetN  in  1  asynchronous, active-low reset.
REQ-005 levelStart  in  1  one-cycle pulse requesting the initial bubble.
REQ-006 initSize  in  3  size of the initial bubble.
REQ-007 initX, initY  in  11 each  top-left corner of the initial bubble.
REQ-008 split  in  NUM_SLOTS  bit k is slot k's split pulse.
REQ-009 bubbleX, bubbleY  in  11*NUM_SLOTS each  slot k's current top-left corner at bits [11k+10:11k].
REQ-010 start  out  NUM_SLOTS  one-cycle launch pulse per slot.
REQ-011 direction  out  NUM_SLOTS  per slot: 1 = right, 0 = left.
REQ-012 startTopX, startTopY  out  11*NUM_SLOTS each  per-slot launch position, same packing as bubbleX.
REQ-013 size  out  3*NUM_SLOTS  per-slot size; slot k at [3k+2:3k].
REQ-014 allClear  out  1  high when no slot is busy, no split is pending, and the FSM is IDLE.
REQ-015 overflow  out  1  sticky flag: a child was dropped because no slot was free.

Function
REQ-016 All outputs shall be registered. Per-slot direction/startTopX/startTopY/size shall hold until the next launch into that slot.
REQ-017 busy[k] shall set on the edge that asserts start[k]. It shall clear on the edge after split[k] is sampled high while busy[k]=1. A split on a non-busy slot shall be ignored.
REQ-018 On a valid split[k] at cycle t, edge t shall set pending[k] and latch bubbleX[k], bubbleY[k] and size[k] into a per-slot parent buffer.
REQ-019 FSM states: IDLE, SPAWN_L, SPAWN_R.
REQ-020 IDLE: if pending is nonzero, latch sel = lowest set pending index.
  - If parent size > 0, go to SPAWN_L.
  - Otherwise clear pending[sel] and stay in IDLE (size-0 bubble is destroyed, no children).
REQ-021 SPAWN_L: allocate f = lowest non-busy slot, then set start[f]=1 (next cycle only), direction[f]=0, startTopX[f]=parentX, startTopY[f]=parentY, size[f]=parent size-1. Go to SPAWN_R.
REQ-022 SPAWN_R: same allocation with direction=1 and startTopX = parentX + (OBJECT_SIZE<<(parent size-1)). Clear pending[sel]. Go to IDLE.
REQ-023 If no slot is free in SPAWN_L or SPAWN_R, drop that child, set overflow, and advance the state as normal.
REQ-024 Latency with FSM idle: split at cycle t gives left child start at t+3 and right child start at t+4.
REQ-025 A parent's own slot is reusable by its children, because busy clears at edge t.
REQ-026 Simultaneous splits shall all be captured and served in ascending slot order, two cycles each (one cycle for size 0).
REQ-027 A split arriving while the FSM is serving another parent shall be captured without loss.
REQ-028 levelStart shall be accepted only when allClear=1 and the FSM is IDLE; otherwise it is ignored.
REQ-029 On an accepted levelStart: next cycle start[0]=1 with direction[0]=1, size[0]=initSize, startTopX[0]=initX, startTopY[0]=initY. overflow shall clear.
REQ-030 Arithmetic: the right-child X sum is 11 bits and cannot exceed parent right edge.
REQ-031 size-1 is computed only when size > 0.

Reset
REQ-032 On resetN low, all of the following shall clear to 0: start, direction, startTopX, startTopY, size, busy, pending, parent buffers, and overflow.
REQ-033 On resetN low, the FSM shall go to IDLE and allClear shall read 1 from the first cycle after reset release.
REQ-034 Reset mid-spawn shall abandon the spawn; no start pulse shall follow reset release.

Structure
REQ-035 Shared package bubble_pkg shall hold NUM_SLOTS, OBJECT_SIZE, MAX_SIZE=4, and the spawner state enum.
REQ-036 One sub-module, bubble_prio_enc: a parameterised lowest-set-bit encoder with valid output.
REQ-037 bubble_prio_enc shall be instantiated twice: once for pending selection and once for free-slot allocation.

Verification
REQ-038 Reset, then levelStart with initSize=3, initX=100, initY=50 -> start[0] next cycle, size[0]=3, direction[0]=1, allClear low.
REQ-039 split[0] at t with bubbleX[0]=100, size 3:
  - start[0] at t+3, X=100, size 2, direction 0.
  - start[1] at t+4, X=132, size 2, direction 1.
REQ-040 split[0] and split[1] in the same cycle, both size 1:
  - Four starts on t+3..t+6.
  - Slot 0's children come first.
  - All four children have size 0.
REQ-041 Size-0 bubble split -> no start pulse; when it was the last busy slot, allClear rises at t+2.
REQ-042 All 8 slots busy, split one size-2 bubble:
  - Left child takes the freed slot.
  - Right child is dropped.
  - overflow=1 until the next accepted levelStart.
REQ-043 levelStart while busy is nonzero -> ignored; resetN pulsed between SPAWN_L and SPAWN_R -> no start after release, all outputs 0.

Source files
------------

// File: rtl/bubble_pkg.sv
// Shared constants and FSM encoding for the bubble spawner.
package bubble_pkg;

  localparam int NUM_SLOTS   = 8;
  localparam int OBJECT_SIZE = 8;
  localparam int MAX_SIZE    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPAWN_L = 2'd1,
    SPAWN_R = 2'd2
  } spawn_state_e;

endpackage

// File: rtl/bubble_prio_enc.sv
// Lowest-set-bit encoder: idx is the lowest asserted bit of req, vld when any bit is set.
module bubble_prio_enc #(
  parameter int W = 8
) (
  input  logic [W-1:0]         req,
  output logic [$clog2(W)-1:0] idx,
  output logic                 vld
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    vld = |req;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = ($clog2(W))'(i);
    end
  end

endmodule

// File: rtl/bubble_spawner.sv
// Bubble spawner: launches the initial bubble and splits parents into two children,
// allocating children to the lowest free bubble_move slot.
module bubble_spawner #(
  parameter int NUM_SLOTS   = bubble_pkg::NUM_SLOTS,
  parameter int OBJECT_SIZE = bubble_pkg::OBJECT_SIZE
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    levelStart,
  input  logic [2:0]              initSize,
  input  logic [10:0]             initX,
  input  logic [10:0]             initY,
  input  logic [NUM_SLOTS-1:0]    split,
  input  logic [11*NUM_SLOTS-1:0] bubbleX,
  input  logic [11*NUM_SLOTS-1:0] bubbleY,
  output logic [NUM_SLOTS-1:0]    start,
  output logic [NUM_SLOTS-1:0]    direction,
  output logic [11*NUM_SLOTS-1:0] startTopX,
  output logic [11*NUM_SLOTS-1:0] startTopY,
  output logic [3*NUM_SLOTS-1:0]  size,
  output logic                    allClear,
  output logic                    overflow
);

  import bubble_pkg::*;

  localparam int IW = $clog2(NUM_SLOTS);

  spawn_state_e state, state_nxt;
  logic [IW-1:0] sel, sel_nxt;

  logic [NUM_SLOTS-1:0] busy, pending, busy_nxt, pending_nxt;
  logic [NUM_SLOTS-1:0] split_ok, clr_mask, launch_mask, sel_oh, pend_req, free_req;
  logic [NUM_SLOTS-1:0][10:0] par_x, par_y;
  logic [NUM_SLOTS-1:0][2:0]  par_s;

  logic [IW-1:0] pidx, fidx;
  logic          pvld, fvld;

  logic          launch, l_dir, ovf_set, lvl_ok, ac_nxt;
  logic [IW-1:0] l_slot;
  logic [10:0]   l_x, l_y, rofs;
  logic [2:0]    l_sz, csz;

  // Splits only count on slots that actually hold a live bubble.
  assign split_ok = split & busy;
  assign sel_oh   = NUM_SLOTS'(1) << sel;
  // While finishing a parent, look past it so the next parent can follow back-to-back.
  assign pend_req = (state == SPAWN_R) ? (pending & ~sel_oh) : pending;
  assign free_req = ~busy;
  // Child size and right-child offset; the guard keeps size 0 from wrapping.
  assign csz  = (par_s[sel] != 3'd0) ? par_s[sel] - 3'd1 : 3'd0;
  assign rofs = 11'(OBJECT_SIZE) << csz;

  bubble_prio_enc #(.W(NUM_SLOTS)) u_pend_enc (.req(pend_req), .idx(pidx), .vld(pvld));
  bubble_prio_enc #(.W(NUM_SLOTS)) u_free_enc (.req(free_req), .idx(fidx), .vld(fvld));

  // Next-state and launch decision.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    launch    = 1'b0;
    l_slot    = fidx;
    l_dir     = 1'b0;
    l_x       = par_x[sel];
    l_y       = par_y[sel];
    l_sz      = csz;
    clr_mask  = '0;
    ovf_set   = 1'b0;
    lvl_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (pvld) begin
          if (par_s[pidx] != 3'd0) begin
            sel_nxt   = pidx;
            state_nxt = SPAWN_L;
          end else begin
            clr_mask = NUM_SLOTS'(1) << pidx;   // size-0 bubble just vanishes
          end
        end else if (levelStart && allClear) begin
          lvl_ok = 1'b1;
          launch = 1'b1;
          l_slot = '0;
          l_dir  = 1'b1;
          l_x    = initX;
          l_y    = initY;
          l_sz   = initSize;
        end
      end
      SPAWN_L: begin
        launch    = fvld;
        ovf_set   = ~fvld;
        state_nxt = SPAWN_R;
      end
      SPAWN_R: begin
        launch    = fvld;
        ovf_set   = ~fvld;
        l_dir     = 1'b1;
        l_x       = par_x[sel] + rofs;
        clr_mask  = sel_oh;
        state_nxt = IDLE;
        if (pvld) begin
          if (par_s[pidx] != 3'd0) begin
            sel_nxt   = pidx;
            state_nxt = SPAWN_L;
          end else begin
            clr_mask = clr_mask | (NUM_SLOTS'(1) << pidx);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign launch_mask = launch ? (NUM_SLOTS'(1) << l_slot) : '0;
  assign busy_nxt    = (busy & ~split_ok) | launch_mask;
  // A fresh split wins over the clear of the parent just finished.
  assign pending_nxt = (pending & ~clr_mask) | split_ok;
  assign ac_nxt      = (busy_nxt == '0) && (pending_nxt == '0) && (state_nxt == IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  // Slot bookkeeping, parent capture and registered launch outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      start     <= '0;
      direction <= '0;
      startTopX <= '0;
      startTopY <= '0;
      size      <= '0;
      busy      <= '0;
      pending   <= '0;
      par_x     <= '0;
      par_y     <= '0;
      par_s     <= '0;
      overflow  <= 1'b0;
      allClear  <= 1'b1;
    end else begin
      start <= '0;
      if (launch) begin
        start[l_slot]               <= 1'b1;
        direction[l_slot]           <= l_dir;
        startTopX[11*l_slot +: 11]  <= l_x;
        startTopY[11*l_slot +: 11]  <= l_y;
        size[3*l_slot +: 3]         <= l_sz;
      end
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (split_ok[k]) begin
          par_x[k] <= bubbleX[11*k +: 11];
          par_y[k] <= bubbleY[11*k +: 11];
          par_s[k] <= size[3*k +: 3];
        end
      end
      busy     <= busy_nxt;
      pending  <= pending_nxt;
      allClear <= ac_nxt;
      if (ovf_set)     overflow <= 1'b1;
      else if (lvl_ok) overflow <= 1'b0;
    end
  end

endmodule
